// File: rtl/niosii_top_nios2_gen2_0_cpu_ocimem_seq.sv
// OCI RAM access sequencer for JTAG debugger commands (system-clock domain).
// Turns take_*_ocimem_* strobes plus the jdo payload into single-word
// read/write requests to a shared arbiter. It returns read data and status
// on MonDReg, monitor_ready and monitor_error.
// Optional: define OCIMEM_SEQ_TIMEOUT_EN to abort a request that goes
// 255 cycles without a grant.
module niosii_top_nios2_gen2_0_cpu_ocimem_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic              mem_gnt,
  input  logic [31:0]       ram_rdata,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              any_stb;

  assign any_stb  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign ram_addr = addr;

  // jdo bits outside the address/flag/data fields carry nothing for us
  logic unused_jdo;
  assign unused_jdo = &{1'b0, jdo[37:36], jdo[1:0]};

`ifdef OCIMEM_SEQ_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`endif

  // Command sequencer: strobe decode, request handshake and status update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      addr          <= '0;
      MonDReg       <= '0;
      ram_wdata     <= '0;
      ram_rd        <= 1'b0;
      ram_wr        <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      busy          <= 1'b0;
`ifdef OCIMEM_SEQ_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // Priority: action_a > action_b > no_action_a; losers are dropped
          if (take_action_ocimem_a) begin
            addr          <= jdo[ADDR_W+1:2];
            monitor_error <= 1'b0;
            if (jdo[35]) begin
              ram_rd        <= 1'b1;
              monitor_ready <= 1'b0;
              busy          <= 1'b1;
              state         <= ST_REQ;
`ifdef OCIMEM_SEQ_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
            end else begin
              monitor_ready <= 1'b1;
            end
          end else if (take_action_ocimem_b) begin
            ram_wdata     <= jdo[34:3];
            ram_wr        <= 1'b1;
            monitor_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_REQ;
`ifdef OCIMEM_SEQ_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end else if (take_no_action_ocimem_a) begin
            ram_rd        <= 1'b1;
            monitor_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_REQ;
`ifdef OCIMEM_SEQ_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (any_stb) monitor_error <= 1'b1;
          if (mem_gnt) begin
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            if (ram_wr) begin
              // write finishes on the grant; no data phase
              addr          <= addr + ADDR_W'(1);
              monitor_ready <= 1'b1;
              busy          <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              state <= ST_RDWAIT;
            end
          end
`ifdef OCIMEM_SEQ_TIMEOUT_EN
          // 255th ungranted cycle: abandon the request, keep addr
          else if (tmo_cnt == 8'd254) begin
            ram_rd        <= 1'b0;
            ram_wr        <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        ST_RDWAIT: begin
          if (any_stb) monitor_error <= 1'b1;
          MonDReg       <= ram_rdata;
          addr          <= addr + ADDR_W'(1);
          monitor_ready <= 1'b1;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          ram_rd <= 1'b0;
          ram_wr <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_top_nios2_gen2_0_cpu_ocimem_seq.sv
// Bench for the OCI RAM sequencer: directed scenarios followed by random
// command traffic. Results are compared with a command-level model
// (address pointer, last read word, error/ready flags, memory image).
module tb_niosii_top_nios2_gen2_0_cpu_ocimem_seq;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              take_a, take_n, take_b;
  logic [37:0]       jdo;
  logic              mem_gnt;
  logic [31:0]       ram_rdata;
  logic              ram_rd, ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, MonDReg;
  logic              monitor_ready, monitor_error, busy;

  int checks = 0;
  int errors = 0;

  // OCI RAM stand-in driven by the DUT's requests
  logic [31:0] ram   [0:255];
  // reference model state
  logic [31:0] m_mem [0:255];
  logic [7:0]  m_addr;
  logic [31:0] m_mon;
  logic        m_err;

  niosii_top_nios2_gen2_0_cpu_ocimem_seq #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_n),
    .take_action_ocimem_b(take_b), .jdo(jdo), .mem_gnt(mem_gnt),
    .ram_rdata(ram_rdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr && mem_gnt) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] ja(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j[31:0]  = $urandom;
    j[37:32] = 6'($urandom);
    j[9:2]   = a;
    j[35]    = rd;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j;
    j[31:0]  = $urandom;
    j[37:32] = 6'($urandom);
    j[34:3]  = d;
    return j;
  endfunction

  task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] j);
    take_a = a; take_b = b; take_n = n; jdo = j;
    step();
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
  endtask

  // run until the sequencer is idle; optional random grant pattern
  task automatic wait_idle(input bit rnd);
    int k;
    k = 0;
    while (busy && k < 300) begin
      mem_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      k++;
    end
    mem_gnt = 1'b1;
    chk("idle_bound", {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_addr"}, {24'b0, ram_addr}, {24'b0, m_addr});
    chk({tag, "_mon"}, MonDReg, m_mon);
    chk({tag, "_err"}, {31'b0, monitor_error}, {31'b0, m_err});
    chk({tag, "_rdy"}, {31'b0, monitor_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    int          op;
    reset_n = 1'b0;
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
    jdo = '0; mem_gnt = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      ram[i] = d; m_mem[i] = d;
    end
    ram[16] = 32'hDEADBEEF; m_mem[16] = 32'hDEADBEEF;
    m_addr = '0; m_mon = '0; m_err = 1'b0;

    // reset state
    step(); step();
    chk("rst_out", {ram_rd, ram_wr, monitor_ready, monitor_error, busy}, 32'd0);
    chk("rst_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_mon", MonDReg, 32'd0);
    reset_n = 1'b1;
    step();

    // load 0x10 with read, immediate grant
    strobe(1'b1, 1'b0, 1'b0, ja(8'h10, 1'b1));
    chk("lr_rd_n1", {31'b0, ram_rd}, 32'd1);
    chk("lr_rdy_n1", {31'b0, monitor_ready}, 32'd0);
    step();
    chk("lr_rdy_n2", {31'b0, monitor_ready}, 32'd0);
    step();
    m_addr = 8'h11; m_mon = 32'hDEADBEEF;
    chk_state("lr_n3");
    chk("lr_busy", {31'b0, busy}, 32'd0);

    // wrap: load 0xFF, write, then read from 0x00
    strobe(1'b1, 1'b0, 1'b0, ja(8'hFF, 1'b0));
    chk("ld_busy", {31'b0, busy}, 32'd0);
    chk("ld_rdy", {31'b0, monitor_ready}, 32'd1);
    strobe(1'b0, 1'b1, 1'b0, jb(32'h12345678));
    chk("wr_n1", {31'b0, ram_wr}, 32'd1);
    step();
    m_mem[255] = 32'h12345678; m_addr = 8'h00;
    chk_state("wrap_wr");
    chk("wrap_mem", ram[255], 32'h12345678);
    strobe(1'b0, 1'b0, 1'b1, ja(8'h00, 1'b0));
    wait_idle(1'b0);
    m_mon = m_mem[0]; m_addr = 8'h01;
    chk_state("wrap_rd");

    // grant stall: write held for 20 cycles
    strobe(1'b1, 1'b0, 1'b0, ja(8'h40, 1'b0));
    m_addr = 8'h40;
    mem_gnt = 1'b0;
    strobe(1'b0, 1'b1, 1'b0, jb(32'hA5A55A5A));
    for (int i = 0; i < 20; i++) begin
      chk("stall_req", {ram_wr, ram_rd, ram_addr, 22'b0}, {2'b10, 8'h40, 22'b0});
      chk("stall_wdata", ram_wdata, 32'hA5A55A5A);
      step();
    end
    mem_gnt = 1'b1;
    step();
    m_mem[8'h40] = 32'hA5A55A5A; m_addr = 8'h41;
    chk("stall_wr_drop", {31'b0, ram_wr}, 32'd0);
    chk_state("stall_done");

    // busy collision during a stalled read
    strobe(1'b1, 1'b0, 1'b0, ja(8'h20, 1'b0));
    mem_gnt = 1'b0;
    strobe(1'b0, 1'b0, 1'b1, ja(8'h00, 1'b0));
    strobe(1'b0, 1'b0, 1'b1, ja(8'h00, 1'b0));
    chk("col_err", {31'b0, monitor_error}, 32'd1);
    chk("col_inflight", {ram_rd, 23'b0, ram_addr}, {1'b1, 23'b0, 8'h20});
    wait_idle(1'b0);
    m_addr = 8'h21; m_mon = m_mem[8'h20]; m_err = 1'b1;
    chk_state("col_done");
    strobe(1'b1, 1'b0, 1'b0, ja(8'h05, 1'b0));
    m_addr = 8'h05; m_err = 1'b0;
    chk_state("col_clear");

    // simultaneous strobes: action_a wins
    strobe(1'b1, 1'b1, 1'b1, ja(8'h33, 1'b0));
    m_addr = 8'h33;
    chk("prio_nowr", {30'b0, ram_wr, busy}, 32'd0);
    chk_state("prio");

    // random command traffic with random grants and collisions
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = 8'($urandom);
        strobe(1'b1, 1'b0, 1'b0, ja(a, 1'($urandom_range(0, 1))));
        m_addr = a; m_err = 1'b0;
        if (jdo[35]) begin m_mon = m_mem[a]; m_addr = a + 8'd1; end
      end else if (op == 1) begin
        d = $urandom;
        strobe(1'b0, 1'b1, 1'b0, jb(d));
        m_mem[m_addr] = d; m_addr = m_addr + 8'd1;
      end else begin
        strobe(1'b0, 1'b0, 1'b1, ja(8'($urandom), 1'b0));
        m_mon = m_mem[m_addr]; m_addr = m_addr + 8'd1;
      end
      if (busy && $urandom_range(0, 3) == 0) begin
        mem_gnt = 1'($urandom_range(0, 1));
        strobe(1'($urandom_range(0, 1)), 1'b1, 1'b1, ja(8'($urandom), 1'b1));
        m_err = 1'b1;
      end
      wait_idle(1'b1);
      chk_state("rnd");
    end
    for (int i = 0; i < 256; i++) chk("rnd_mem", ram[i], m_mem[i]);

    // asynchronous reset while a read is waiting for grant
    mem_gnt = 1'b0;
    strobe(1'b1, 1'b0, 1'b0, ja(8'h77, 1'b1));
    chk("rstmid_rd", {31'b0, ram_rd}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_out", {ram_rd, ram_wr, monitor_ready, monitor_error, busy}, 32'd0);
    chk("rstmid_regs", {ram_addr, 24'b0} | MonDReg | ram_wdata, 32'd0);
    step();
    reset_n = 1'b1;
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstmid_norq", {30'b0, ram_rd, busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
